// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding, access
// size codes, lsu_op field positions and lane-offset helpers.
package lsu_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_RESP = 2'd3
    } lsu_state_t;

    localparam logic [1:0] LSU_SIZE_B = 2'd0;
    localparam logic [1:0] LSU_SIZE_H = 2'd1;
    localparam logic [1:0] LSU_SIZE_W = 2'd2;

    // lsu_op = {is_store, signed_n, size[1:0]}
    localparam int LSU_OP_STORE   = 3;
    localparam int LSU_OP_UNS     = 2;
    localparam int LSU_OP_SIZE_HI = 1;
    localparam int LSU_OP_SIZE_LO = 0;

    // Byte offset actually used on the bus: halves align to the half, words
    // (and the unused size code 3) align to the word.
    function automatic logic [1:0] lsu_lane_off(input logic [1:0] size, input logic [1:0] off);
        logic [1:0] r;
        case (size)
            LSU_SIZE_B: r = off;
            LSU_SIZE_H: r = {off[1], 1'b0};
            default:    r = 2'b00;
        endcase
        return r;
    endfunction

    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic r;
        case (size)
            LSU_SIZE_B: r = 1'b0;
            LSU_SIZE_H: r = off[0];
            default:    r = (off != 2'b00);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Single-beat data-memory bus between the LSU (master) and memory (slave).
interface lsu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_reqValid;
    logic              mem_reqReady;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_respValid;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_respErr;

    modport master (
        output mem_reqValid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
        input  mem_reqReady, mem_respValid, mem_rdata, mem_respErr
    );

    modport slave (
        input  mem_reqValid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
        output mem_reqReady, mem_respValid, mem_rdata, mem_respErr
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU: store byte-lane replication and
// strobes, misalignment detection, and load lane extraction with extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        req_op_i,
    input  logic [1:0]        req_off_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic [DATA_W-1:0] req_wdata_o,
    output logic [3:0]        req_wstrb_o,
    output logic              req_misalign_o,
    input  logic [2:0]        rsp_op_i,
    input  logic [1:0]        rsp_off_i,
    input  logic [DATA_W-1:0] rsp_rdata_i,
    output logic [DATA_W-1:0] rsp_data_o
);

    logic [1:0]        req_size;
    logic [1:0]        req_lane;
    logic [1:0]        rsp_lane;
    logic [DATA_W-1:0] rsp_shift;

    assign req_size       = req_op_i[LSU_OP_SIZE_HI:LSU_OP_SIZE_LO];
    assign req_lane       = lsu_lane_off(req_size, req_off_i);
    assign req_misalign_o = lsu_misaligned(req_size, req_off_i);

    // Store path: replicate the right-aligned datum into every lane it could occupy
    always_comb begin
        req_wdata_o = req_wdata_i;
        req_wstrb_o = 4'b1111;
        case (req_size)
            LSU_SIZE_B: begin
                req_wdata_o = {4{req_wdata_i[7:0]}};
                req_wstrb_o = 4'b0001 << req_lane;
            end
            LSU_SIZE_H: begin
                req_wdata_o = {2{req_wdata_i[15:0]}};
                req_wstrb_o = 4'b0011 << req_lane;
            end
            default: ;
        endcase
        if (!req_op_i[LSU_OP_STORE]) begin
            req_wstrb_o = 4'b0000;
        end
    end

    assign rsp_lane  = lsu_lane_off(rsp_op_i[1:0], rsp_off_i);
    assign rsp_shift = rsp_rdata_i >> {rsp_lane, 3'b000};

    // Load path: pick the addressed lane, sign-extend unless signed_n is set
    always_comb begin
        rsp_data_o = rsp_rdata_i;
        case (rsp_op_i[1:0])
            LSU_SIZE_B: rsp_data_o = rsp_op_i[LSU_OP_UNS] ? {24'd0, rsp_shift[7:0]}
                                                          : {{24{rsp_shift[7]}}, rsp_shift[7:0]};
            LSU_SIZE_H: rsp_data_o = rsp_op_i[LSU_OP_UNS] ? {16'd0, rsp_shift[15:0]}
                                                          : {{16{rsp_shift[15]}}, rsp_shift[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one memory op from execute, performs a single-beat
// bus access and returns extended load data with a one-cycle respValid pulse.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned accesses bypass
// the bus and complete with lsu_err=1; otherwise they are force-aligned).
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              reqValid,
    input  logic [3:0]        lsu_op,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    output logic              respValid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_err,
    output logic              busy,
    lsu_if.master             mem
);

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif

    lsu_state_t        state_q;
    logic [3:0]        op_q;
    logic [1:0]        off_q;
    logic              respValid_q;
    logic [DATA_W-1:0] lsu_rdata_q;
    logic              lsu_err_q;
    logic              mem_reqValid_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_wen_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [3:0]        mem_wstrb_q;

    logic [DATA_W-1:0] st_wdata;
    logic [3:0]        st_wstrb;
    logic              misalign;
    logic              trap;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] rsp_data_d;

    lsu_align #(.DATA_W(DATA_W)) u_align (
        .req_op_i       (lsu_op),
        .req_off_i      (lsu_addr[1:0]),
        .req_wdata_i    (lsu_wdata),
        .req_wdata_o    (st_wdata),
        .req_wstrb_o    (st_wstrb),
        .req_misalign_o (misalign),
        .rsp_op_i       (op_q[2:0]),
        .rsp_off_i      (off_q),
        .rsp_rdata_i    (mem.mem_rdata),
        .rsp_data_o     (ld_data)
    );

    assign trap       = TrapEn & misalign;
    assign rsp_data_d = (mem.mem_respErr || op_q[LSU_OP_STORE]) ? '0 : ld_data;

    // Hold the accepted op and low address bits for response-side extraction
    always_ff @(posedge clock) begin
        if (state_q == LSU_IDLE && reqValid) begin
            op_q  <= lsu_op;
            off_q <= lsu_addr[1:0];
        end
    end

    // Access sequencer with registered bus and response outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= LSU_IDLE;
            respValid_q    <= 1'b0;
            lsu_rdata_q    <= '0;
            lsu_err_q      <= 1'b0;
            mem_reqValid_q <= 1'b0;
            mem_addr_q     <= '0;
            mem_wen_q      <= 1'b0;
            mem_wdata_q    <= '0;
            mem_wstrb_q    <= '0;
        end else begin
            case (state_q)
                LSU_IDLE: begin
                    if (reqValid) begin
                        if (trap) begin
                            // Trapped access: RESP is entered one cycle early so the pulse lands at +2
                            lsu_rdata_q <= '0;
                            lsu_err_q   <= 1'b1;
                            state_q     <= LSU_RESP;
                        end else begin
                            mem_reqValid_q <= 1'b1;
                            mem_addr_q     <= {lsu_addr[ADDR_W-1:2], 2'b00};
                            mem_wen_q      <= lsu_op[LSU_OP_STORE];
                            mem_wdata_q    <= st_wdata;
                            mem_wstrb_q    <= st_wstrb;
                            state_q        <= LSU_REQ;
                        end
                    end
                end
                LSU_REQ: begin
                    if (mem.mem_reqReady) begin
                        mem_reqValid_q <= 1'b0;
                        if (mem.mem_respValid) begin
                            lsu_rdata_q <= rsp_data_d;
                            lsu_err_q   <= mem.mem_respErr;
                            respValid_q <= 1'b1;
                            state_q     <= LSU_RESP;
                        end else begin
                            state_q <= LSU_WAIT;
                        end
                    end
                end
                LSU_WAIT: begin
                    if (mem.mem_respValid) begin
                        lsu_rdata_q <= rsp_data_d;
                        lsu_err_q   <= mem.mem_respErr;
                        respValid_q <= 1'b1;
                        state_q     <= LSU_RESP;
                    end
                end
                LSU_RESP: begin
                    if (respValid_q) begin
                        respValid_q <= 1'b0;
                        state_q     <= LSU_IDLE;
                    end else begin
                        respValid_q <= 1'b1;
                    end
                end
                default: state_q <= LSU_IDLE;
            endcase
        end
    end

    assign respValid        = respValid_q;
    assign lsu_rdata        = lsu_rdata_q;
    assign lsu_err          = lsu_err_q;
    assign busy             = (state_q != LSU_IDLE);
    assign mem.mem_reqValid = mem_reqValid_q;
    assign mem.mem_addr     = mem_addr_q;
    assign mem.mem_wen      = mem_wen_q;
    assign mem.mem_wdata    = mem_wdata_q;
    assign mem.mem_wstrb    = mem_wstrb_q;

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit directly downstream of the execute stage.
- Consumes the execute stage's address, store data and memory-op request; issues a single-beat access on the data-memory bus.
- Returns sign/zero-extended load data plus a one-cycle completion pulse; the execute stage holds in its LSU-stall state until the pulse arrives.
- One outstanding access at a time.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; only 32 is supported

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- reqValid  in  1  execute stage requests a memory op; op fields valid this cycle
- lsu_op  in  4  {is_store, signed_n, size[1:0]}; size 0=B, 1=H, 2=W
- lsu_addr  in  ADDR_W  byte address
- lsu_wdata  in  DATA_W  store data, right-aligned
- respValid  out  1  one-cycle completion pulse
- lsu_rdata  out  DATA_W  extended load data; 0 for stores
- lsu_err  out  1  error flag, qualified by respValid
- busy  out  1  access in flight (state != LSU_IDLE)
- mem_reqValid  out  1  bus request valid
- mem_reqReady  in  1  bus accepts request
- mem_addr  out  ADDR_W  word-aligned address ({lsu_addr[31:2],2'b00})
- mem_wen  out  1  write request
- mem_wdata  out  DATA_W  store data replicated to byte lanes
- mem_wstrb  out  4  byte-lane strobes; 0 for reads
- mem_respValid  in  1  bus response valid
- mem_rdata  in  DATA_W  bus read word
- mem_respErr  in  1  bus error, qualified by mem_respValid

Behaviour:
- Reset (reset==0, asynchronous): state=LSU_IDLE. respValid, lsu_rdata, lsu_err, mem_reqValid, mem_addr, mem_wen, mem_wdata and mem_wstrb are all 0.
- States: LSU_IDLE, LSU_REQ, LSU_WAIT, LSU_RESP.
- LSU_IDLE: on reqValid, register op, addr[1:0] and the lane-aligned request fields, then go to LSU_REQ. reqValid outside LSU_IDLE is ignored; the execute stage holds its request.
- LSU_REQ: mem_reqValid=1 with stable addr/wen/wdata/wstrb until mem_reqReady. Handshake when both are 1:
  - if mem_respValid is also 1 that cycle, go to LSU_RESP and capture the response;
  - otherwise go to LSU_WAIT.
- LSU_WAIT: mem_reqValid=0. On mem_respValid, capture mem_rdata and mem_respErr, then go to LSU_RESP.
- LSU_RESP: respValid=1 for exactly one cycle with registered lsu_rdata and lsu_err, then go to LSU_IDLE.
- Latency: minimum reqValid -> respValid is 2 cycles (same-cycle ready+response). Each bus wait cycle adds one.
- Loads: extract the lane selected by addr[1:0]:
  - B uses byte addr[1:0];
  - H uses half addr[1];
  - signed_n=0 sign-extends, signed_n=1 zero-extends;
  - W passes the word through.
- Stores:
  - B: wstrb=0001<<addr[1:0], wdata={4{b}};
  - H: wstrb=0011<<{addr[1],0}, wdata={2{h}};
  - W: wstrb=1111.
- Misalignment: H with addr[0]=1, or W with addr[1:0]!=0, is handled per the optional feature.
- Errors: on mem_respErr, lsu_rdata=0 and lsu_err=1; no retry.
- Reset mid-access returns the block to LSU_IDLE immediately. A bus response arriving afterwards while in LSU_IDLE is ignored.
- respValid never asserts without a preceding accepted reqValid.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned access skips the bus entirely and goes LSU_IDLE -> LSU_RESP. It returns respValid with lsu_err=1 and lsu_rdata=0 two cycles after reqValid.
- Undefined: the offending low address bits are forced to 0 (H aligns to the half, W to the word), the access proceeds normally, and lsu_err reflects only mem_respErr.

Decomposition:
- Shared package lsu_pkg: lsu_state_t enum; LSU_SIZE_B/H/W constants; lsu_op field positions.
- One sub-module, lsu_align (combinational):
  - store lane/strobe generation;
  - load extract and extend;
  - misalignment detection.

Test Plan:
- LB at addr 0x103, mem_rdata=0x80_00_00_00, ready and response same cycle -> respValid 2 cycles after reqValid, lsu_rdata=0xFFFFFF80, lsu_err=0.
- LHU at 0x102, mem_rdata=0xBEEF1234, 3 wait cycles -> lsu_rdata=0x0000BEEF, respValid 5 cycles after reqValid, single-cycle pulse.
- SB at 0x201 with wdata=0x000000AB -> mem_addr=0x200, mem_wstrb=0010, mem_wdata=0xABABABAB, mem_wen=1; lsu_rdata=0 on completion.
- LW at 0x300 with mem_reqReady held 0 for 4 cycles -> mem_reqValid and address stable throughout; response with mem_respErr=1 -> lsu_err=1, lsu_rdata=0.
- SW at 0x402:
  - with LSU_MISALIGN_TRAP_EN -> no mem_reqValid, lsu_err=1 at cycle +2;
  - without -> mem_addr=0x400, wstrb=1111.
- reset driven to 0 while in LSU_WAIT, released, then a stray mem_respValid arrives -> all outputs 0, state LSU_IDLE, respValid stays 0.
